div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the EX stage, signed and unsigned. It raises `stallreq_for_ex` toward the pipeline controller for as long as a division is in flight, which freezes the pipeline. It accepts the controller's `flush` to abort, and presents quotient and remainder for one cycle when the operation completes. It uses radix-2 restoring division over operand magnitudes, with a sign fix-up at the end.

---
 rtl/div_unit.sv | 152 +++++++++++++++
 tb/tb_div_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX stage.
// Works on operand magnitudes and applies the sign fix-up on the final
// iteration. Stalls the pipeline while busy; flush aborts at any time.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stallreq_for_ex,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ZERO, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] dvd_orig_q, dvd_orig_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quo_work_q, quo_work_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] quo_next;
  logic             a_neg, b_neg;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Datapath for the current restoring iteration.
  always_comb begin
    shifted   = {prem_q, quo_work_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_mag_q};
    prem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next  = {quo_work_q[WIDTH-2:0], ~diff[WIDTH]};
    a_neg     = signed_op & dividend[WIDTH-1];
    b_neg     = signed_op & divisor[WIDTH-1];
  end

  // Next-state and register-update logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dvd_orig_d  = dvd_orig_q;
    dvs_mag_d   = dvs_mag_q;
    prem_d      = prem_q;
    quo_work_d  = quo_work_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          signed_d   = signed_op;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          dvd_orig_d = dividend;
          quo_work_d = neg_if(a_neg, dividend);
          dvs_mag_d  = neg_if(b_neg, divisor);
          prem_d     = '0;
          cnt_d      = '0;
          state_d    = (divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        prem_d     = prem_next;
        quo_work_d = quo_next;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          quotient_d  = neg_if(signed_q & qneg_q, quo_next);
          remainder_d = neg_if(signed_q & rneg_q, prem_next);
          state_d     = DONE;
        end
      end
      ZERO: begin
        quotient_d  = '1;
        remainder_d = dvd_orig_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dvd_orig_q  <= '0;
      dvs_mag_q   <= '0;
      prem_q      <= '0;
      quo_work_q  <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dvd_orig_q  <= dvd_orig_d;
      dvs_mag_q   <= dvs_mag_d;
      prem_q      <= prem_d;
      quo_work_q  <= quo_work_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Stall covers the accept cycle and every busy cycle, never DONE or flush.
  always_comb begin
    stallreq_for_ex = rst_n & ~flush &
                      (((state_q == IDLE) & start) | (state_q == CALC) | (state_q == ZERO));
    result_valid    = (state_q == DONE);
    quotient        = quotient_q;
    remainder       = remainder_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed cases, randomized operations checked
// against an arithmetic reference model, flush and mid-operation reset.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         stallreq_for_ex;
  logic         result_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int vectors = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .stallreq_for_ex(stallreq_for_ex),
    .result_valid(result_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division truncating toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sg, output logic [W-1:0] q,
                                output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drives one operation with start held; returns the cycle of result_valid
  // (-1 if none within the budget), whether stall behaved, and the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        output int vcycle, output logic stall_ok,
                        output logic [W-1:0] q, output logic [W-1:0] r);
    @(negedge clk);
    dividend = a; divisor = b; signed_op = sg; start = 1'b1;
    vcycle = -1; stall_ok = 1'b1; q = 'x; r = 'x;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (result_valid) begin
        vcycle = c; q = quotient; r = remainder;
        if (stallreq_for_ex) stall_ok = 1'b0;
        break;
      end else if (!stallreq_for_ex) begin
        stall_ok = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (quotient !== '0 || remainder !== '0) begin
      miscompares++;
      $display("FAIL reset_data: q=%h r=%h required 0/0", quotient, remainder);
    end
    vectors++;
    if (result_valid !== 1'b0 || stallreq_for_ex !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: valid=%b stall=%b required 0/0", result_valid, stallreq_for_ex);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h1234, 32'h80000000, 32'h80000000};
    logic [W-1:0] tb [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic         ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] eq [6] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    logic [W-1:0] er [6] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h1234, 32'd0, 32'h80000000};
    int vc; logic sok; logic [W-1:0] q, r; int elat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], ts[i], vc, sok, q, r);
      elat = (tb[i] == '0) ? 2 : W + 1;
      vectors++;
      if (vc !== elat) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d required %0d", i, vc, elat);
      end
      vectors++;
      if (sok !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_stall: stall pattern wrong, got ok=%b required 1", i, sok);
      end
      vectors++;
      if (q !== eq[i] || r !== er[i]) begin
        miscompares++;
        $display("FAIL dir%0d_result: q=%h r=%h required q=%h r=%h", i, q, r, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_random;
    int vc; logic sok; logic [W-1:0] a, b, q, r, eq, er; logic sg; int elat;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 300));
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = '1;
        3: b = 32'h80000000;
        default: b = $urandom;
      endcase
      sg = 1'($urandom_range(0, 1));
      model(a, b, sg, eq, er);
      elat = (b == '0) ? 2 : W + 1;
      run_op(a, b, sg, vc, sok, q, r);
      vectors++;
      if (vc !== elat || sok !== 1'b1 || q !== eq || r !== er) begin
        miscompares++;
        $display("FAIL rand%0d: %h/%h s=%b got q=%h r=%h lat=%0d stall_ok=%b required q=%h r=%h lat=%0d",
                 i, a, b, sg, q, r, vc, sok, eq, er, elat);
      end
    end
  endtask

  task automatic test_flush;
    int vc; logic sok; logic [W-1:0] q, r, pq, pr;
    logic seen_valid;
    // Establish known held outputs first.
    run_op(32'd1000, 32'd9, 1'b0, vc, sok, pq, pr);
    model(32'd1000, 32'd9, 1'b0, pq, pr);
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    seen_valid = 1'b0; vc = -1;
    for (int c = 0; c <= 48; c++) begin
      if (c == 10) flush = 1'b1;
      if (c == 11) begin flush = 1'b0; start = 1'b0; end
      if (c == 12) begin dividend = 32'd50; divisor = 32'd6; start = 1'b1; end
      #1;
      if (c == 10 || c == 11) begin
        vectors++;
        if (stallreq_for_ex !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_stall_c%0d: got %b required 0", c, stallreq_for_ex);
        end
      end
      if (c == 11) begin
        vectors++;
        if (quotient !== pq || remainder !== pr) begin
          miscompares++;
          $display("FAIL flush_hold: q=%h r=%h required q=%h r=%h", quotient, remainder, pq, pr);
        end
      end
      if (result_valid && c < 45) seen_valid = 1'b1;
      if (result_valid && c >= 45 && vc < 0) begin
        vc = c; q = quotient; r = remainder;
      end
      if (c == 45) start = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_valid: got valid before cycle 45, required none");
    end
    vectors++;
    if (vc !== 45 || q !== 32'd8 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL flush_restart: cycle=%0d q=%h r=%h required cycle=45 q=8 r=2", vc, q, r);
    end
  endtask

  task automatic test_reset_mid;
    logic bad;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (quotient !== '0 || remainder !== '0 || result_valid !== 1'b0 || stallreq_for_ex !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: q=%h r=%h valid=%b stall=%b required all 0",
               quotient, remainder, result_valid, stallreq_for_ex);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stallreq_for_ex !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: stall or valid seen, required none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
